mult_par_pipe: RTL and testbench

Parametrised signed multiplier with even-parity checking on both operands. It is the pipelined successor of the single-shot 16x16 parity multiplier. Operands are accepted through a req/ack handshake, up to FIFO_DEPTH operations may be in flight, and results return in order from an output FIFO with a result_rdy/result_ack handshake. It sits at the block level under the existing multiplier UVM bench.

---
 rtl/mult_par_pipe.sv | 116 +++++++++++
 tb/tb_mult_par_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_par_pipe.sv
// Pipelined signed W x W multiplier with even-parity operand checking, credit-limited
// req/ack intake and an in-order result FIFO. Define MULT_ERR_CNT_EN to add err_count.
module mult_par_pipe #(
  parameter int W          = 16,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req,
  input  logic [W-1:0]                          arg_a,
  input  logic                                  arg_a_parity,
  input  logic [W-1:0]                          arg_b,
  input  logic                                  arg_b_parity,
  output logic                                  ack,
  output logic [2*W-1:0]                        result,
  output logic                                  result_parity,
  output logic                                  arg_parity_error,
  output logic                                  result_rdy,
  input  logic                                  result_ack,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       outstanding
`ifdef MULT_ERR_CNT_EN
  ,
  output logic [15:0]                           err_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 2 * W + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW:0]   ONE_P   = (AW + 1)'(1);

  logic          accept;
  logic          pop;
  logic          push;
  logic          in_err;
  logic [2*W-1:0] prod;
  logic [PW-1:0] in_ent;
  logic [PW-1:0] head;
  logic [PW-1:0] last_ent;

  logic [PW-1:0] st_ent [LAT];
  logic [LAT-1:0] st_vld;

  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign ack    = req && (outstanding < DEPTH_C);
  assign accept = ack;

  assign in_err = ((^arg_a) != arg_a_parity) || ((^arg_b) != arg_b_parity);
  assign prod   = $signed(arg_a) * $signed(arg_b);
  // Entry layout: {product, product parity, parity error}
  assign in_ent = in_err ? {{(2*W+1){1'b0}}, 1'b1} : {prod, ^prod, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_vld <= '0;
    end else begin
      st_vld[0] <= accept;
      for (int i = 1; i < LAT; i++) st_vld[i] <= st_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    st_ent[0] <= in_ent;
    for (int i = 1; i < LAT; i++) st_ent[i] <= st_ent[i-1];
  end

  assign push       = st_vld[LAT-1];
  assign result_rdy = (wr_ptr != rd_ptr);
  assign pop        = result_rdy && result_ack;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= st_ent[LAT-1];
  end

  // Credits cap in-flight work at FIFO_DEPTH, so push never finds the FIFO full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      last_ent    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_P;
      if (pop) begin
        rd_ptr   <= rd_ptr + ONE_P;
        last_ent <= mem[rd_ptr[AW-1:0]];
      end
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + ONE_C;
        2'b01:   outstanding <= outstanding - ONE_C;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // An empty FIFO shows the last popped entry rather than stale slot contents.
  assign head = result_rdy ? mem[rd_ptr[AW-1:0]] : last_ent;
  assign {result, result_parity, arg_parity_error} = head;

`ifdef MULT_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && in_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_par_pipe.sv
// Self-checking bench for mult_par_pipe: vector table plus scoreboard queue, with
// hand-written backpressure, throughput and mid-flight reset sequences.
module tb_mult_par_pipe;
  localparam int W   = 16;
  localparam int LAT = 2;
  localparam int FD  = 4;
  localparam int CW  = $clog2(FD + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req = 1'b0;
  logic [W-1:0]   arg_a = '0;
  logic           arg_a_parity = 1'b0;
  logic [W-1:0]   arg_b = '0;
  logic           arg_b_parity = 1'b0;
  logic           result_ack = 1'b0;
  logic           ack;
  logic [2*W-1:0] result;
  logic           result_parity;
  logic           arg_parity_error;
  logic           result_rdy;
  logic [CW-1:0]  outstanding;
`ifdef MULT_ERR_CNT_EN
  logic [15:0]    err_count;
`endif

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           par;
    logic           err;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic         pa;
    logic [W-1:0] b;
    logic         pb;
    exp_t         e;
  } vec_t;

  vec_t vecs [10];
  exp_t sb [$];
  int   pop_cyc [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   acc_cyc = 0;
  int   acc0 = 0;
  int   max_out = 0;
  bit   tp_mon = 1'b0;

  mult_par_pipe #(.W(W), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .arg_parity_error (arg_parity_error),
    .result_rdy       (result_rdy),
    .result_ack       (result_ack),
    .outstanding      (outstanding)
`ifdef MULT_ERR_CNT_EN
    ,
    .err_count        (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic pa,
                                 input logic [W-1:0] b, input logic pb);
    exp_t e;
    logic signed [2*W-1:0] p;
    e.err = ((^a) != pa) || ((^b) != pb);
    p = $signed(a) * $signed(b);
    e.res = e.err ? '0 : p;
    e.par = ^e.res;
    return e;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic pa, input logic [W-1:0] b,
                              input logic pb, input logic [2*W-1:0] res, input logic par,
                              input logic err);
    vec_t v;
    v.a = a; v.pa = pa; v.b = b; v.pb = pb;
    v.e.res = res; v.e.par = par; v.e.err = err;
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output side: pop and compare against the scoreboard on every handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (tp_mon && int'(outstanding) > max_out) max_out = int'(outstanding);
    if (rst_n && result_rdy && result_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(result_rdy), 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("result_parity", 64'(result_parity), 64'(e.par));
        check("arg_parity_error", 64'(arg_parity_error), 64'(e.err));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Call at #1 after a posedge; returns at #1 after the accepting edge with req still high.
  task automatic send(input logic [W-1:0] a, input logic pa, input logic [W-1:0] b,
                      input logic pb, input exp_t e, output int waits);
    logic got;
    arg_a = a; arg_a_parity = pa; arg_b = b; arg_b_parity = pb; req = 1'b1;
    waits = 0;
    got = 1'b0;
    while (!got && waits <= 100) begin
      @(negedge clk);
      got = ack;
      @(posedge clk);
      #1;
      if (!got) waits++;
    end
    if (got) begin
      sb.push_back(e);
      acc_cyc = cyc;
    end else begin
      check("ack_timeout", 64'(got), 64'd1);
    end
  endtask

  task automatic send_vec(input int i, output int waits);
    send(vecs[i].a, vecs[i].pa, vecs[i].b, vecs[i].pb, vecs[i].e, waits);
  endtask

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, output int waits);
    send(a, ^a, b, ^b, model(a, ^a, b, ^b), waits);
  endtask

  task automatic drain();
    req = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int w;
    exp_t e5;
    logic [W-1:0] a5, b5;

    vecs[0] = mk(16'h0003, 1'b0, 16'hFFFE, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0);
    vecs[1] = mk(16'h0001, 1'b0, 16'h0005, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    vecs[2] = mk(16'h8000, 1'b1, 16'h8000, 1'b1, 32'h4000_0000, 1'b1, 1'b0);
    vecs[3] = mk(16'h7FFF, 1'b1, 16'h8000, 1'b1, 32'hC000_8000, 1'b1, 1'b0);
    vecs[4] = mk(16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 32'h3FFF_0001, 1'b1, 1'b0);
    vecs[5] = mk(16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
    vecs[6] = mk(16'h0000, 1'b0, 16'h1234, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    vecs[7] = mk(16'h0002, 1'b1, 16'h0003, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    vecs[8] = mk(16'h0010, 1'b1, 16'hFFF0, 1'b0, 32'hFFFF_FF00, 1'b0, 1'b0);
    vecs[9] = mk(16'h0101, 1'b0, 16'h0003, 1'b0, 32'h0000_0303, 1'b0, 1'b0);

    // Reset state
    #12;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_result_rdy", 64'(result_rdy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_parity", 64'(result_parity), 64'd0);
    check("rst_arg_parity_error", 64'(arg_parity_error), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
`ifdef MULT_ERR_CNT_EN
    check("rst_err_count", 64'(err_count), 64'd0);
`endif
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b1;

    // Basic product and first-result latency
    pop_cyc.delete();
    send_vec(0, w);
    drain();
    check("t1_pop_count", 64'(pop_cyc.size()), 64'd1);
    if (pop_cyc.size() > 0) check("t1_latency", 64'(pop_cyc[0] - acc_cyc), 64'(LAT));

    // Parity error
    send_vec(1, w);
    drain();
`ifdef MULT_ERR_CNT_EN
    check("t2_err_count", 64'(err_count), 64'd1);
`endif

    // Throughput over the remaining table vectors, including the 0x8000 corners
    pop_cyc.delete();
    max_out = 0;
    tp_mon = 1'b1;
    for (int i = 2; i < 10; i++) begin
      send_vec(i, w);
      check("tp_ack_wait", 64'(w), 64'd0);
      if (i == 2) acc0 = acc_cyc;
    end
    drain();
    tp_mon = 1'b0;
    check("tp_pop_count", 64'(pop_cyc.size()), 64'd8);
    for (int i = 0; i < pop_cyc.size(); i++)
      check("tp_pop_cycle", 64'(pop_cyc[i] - acc0), 64'(LAT + i));
    check("tp_max_outstanding_ok", 64'(max_out <= LAT + 1), 64'd1);
`ifdef MULT_ERR_CNT_EN
    check("tp_err_count", 64'(err_count), 64'd2);
`endif

    // Backpressure: four credits, fifth waits for the first pop
    result_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_op(16'h0100 + 16'(k), 16'hFF00 - 16'(k), w);
      check("bp_ack_wait", 64'(w), 64'd0);
    end
    a5 = 16'h0104; b5 = 16'hFEFB;
    e5 = model(a5, ^a5, b5, ^b5);
    arg_a = a5; arg_a_parity = ^a5; arg_b = b5; arg_b_parity = ^b5; req = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk);
      check("bp_ack_full", 64'(ack), 64'd0);
    end
    check("bp_outstanding_full", 64'(outstanding), 64'd4);
    @(posedge clk);
    #1 result_ack = 1'b1;
    @(negedge clk);
    check("bp_ack_before_pop", 64'(ack), 64'd0);
    @(posedge clk);
    #1 result_ack = 1'b0;
    @(negedge clk);
    check("bp_ack_after_pop", 64'(ack), 64'd1);
    @(posedge clk);
    #1 sb.push_back(e5);
    check("bp_outstanding_refill", 64'(outstanding), 64'd4);
    result_ack = 1'b1;
    send_op(16'h0105, 16'hFEFA, w);
    drain();

    // Mid-flight reset discards everything
    result_ack = 1'b0;
    send_op(16'h0033, 16'h0044, w);
    send_op(16'h0055, 16'h0066, w);
    req = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check("mr_rdy_before", 64'(result_rdy), 64'd1);
    check("mr_outstanding_before", 64'(outstanding), 64'd2);
    rst_n = 1'b0;
    #2;
    check("mr_rdy", 64'(result_rdy), 64'd0);
    check("mr_outstanding", 64'(outstanding), 64'd0);
    check("mr_result", 64'(result), 64'd0);
`ifdef MULT_ERR_CNT_EN
    check("mr_err_count", 64'(err_count), 64'd0);
`endif
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    result_ack = 1'b1;
    repeat (2 * LAT + 4) begin
      @(negedge clk);
      check("mr_no_ghost", 64'(result_rdy), 64'd0);
    end
    @(posedge clk);
    #1;
    send_op(16'hFFFD, 16'h0007, w);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
